// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate data cache
// between the MEM stage hold-until-resp port and the physical-memory port.
module dcache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_b,
    input  logic        write,
    input  logic [3:0]  wmask,
    input  logic [31:0] address_b,
    input  logic [31:0] wdata,
    output logic        resp_b,
    output logic [31:0] rdata_b,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_wmask,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);
    localparam int N  = 1 << S_INDEX;
    localparam int TW = 30 - S_INDEX;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE_MEM} state_t;

    state_t state, state_nxt;

    logic [N-1:0]       valid;
    logic [TW-1:0]      tag_q  [N];
    logic [31:0]        data_q [N];

    logic [S_INDEX-1:0] idx;
    logic [TW-1:0]      tag_in;
    logic               hit;
    logic               fill_en;
    logic               wr_hit_en;
    logic               addr_unused;

    assign idx         = address_b[S_INDEX+1:2];
    assign tag_in      = address_b[31:S_INDEX+2];
    assign hit         = valid[idx] && (tag_q[idx] == tag_in);
    assign addr_unused = ^address_b[1:0];

    assign fill_en   = (state == FETCH) && pmem_resp;
    assign wr_hit_en = (state == WRITE_MEM) && pmem_resp && hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (write)                state_nxt = WRITE_MEM;
                else if (read_b && !hit)  state_nxt = FETCH;
            end
            FETCH:     if (pmem_resp) state_nxt = IDLE;
            WRITE_MEM: if (pmem_resp) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_b       = 1'b0;
        rdata_b      = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_wmask   = '0;
        case (state)
            IDLE: begin
                // Read hits answer in the request cycle so the MEM stage never stalls on them
                if (read_b && !write && hit) begin
                    resp_b  = 1'b1;
                    rdata_b = data_q[idx];
                end
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {address_b[31:2], 2'b00};
            end
            WRITE_MEM: begin
                pmem_write   = 1'b1;
                pmem_address = {address_b[31:2], 2'b00};
                pmem_wdata   = wdata;
                pmem_wmask   = wmask;
                resp_b       = pmem_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       valid      <= '0;
        else if (fill_en) valid[idx] <= 1'b1;
    end

    // Tag/data carry no reset; valid alone guards them
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag_in;
            data_q[idx] <= pmem_rdata;
        end else if (wr_hit_en) begin
            for (int i = 0; i < 4; i++)
                if (wmask[i]) data_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder.
module tb_dcache_responder;
    logic        clk;
    logic        reset;
    logic        read_b;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address_b;
    logic [31:0] wdata;
    logic        resp_b;
    logic [31:0] rdata_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int n_checks = 0;
    int n_fails  = 0;

    dcache_responder #(.S_INDEX(3)) dut (
        .clk(clk), .reset(reset),
        .read_b(read_b), .write(write), .wmask(wmask),
        .address_b(address_b), .wdata(wdata),
        .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs are driven, then outputs checked after #1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; read_b = 1'b0; write = 1'b0; wmask = '0;
        address_b = '0; wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        check("rst_resp_b", {31'b0, resp_b}, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_pmem_read", {31'b0, pmem_read}, 32'h0);
        check("rst_pmem_write", {31'b0, pmem_write}, 32'h0);
        check("rst_pmem_address", pmem_address, 32'h0);
        reset = 1'b1;
        tick();

        // stray pmem_resp in IDLE is ignored
        pmem_resp = 1'b1; #1;
        check("idle_resp_ignored", {31'b0, resp_b}, 32'h0);
        tick(); pmem_resp = 1'b0;
        check("idle_no_pmem_read", {31'b0, pmem_read}, 32'h0);

        // 1: read miss 0x100, pmem answers on the third FETCH cycle
        read_b = 1'b1; address_b = 32'h0000_0101; #1;
        check("t1_miss_no_resp", {31'b0, resp_b}, 32'h0);
        tick();
        check("t1_pmem_read", {31'b0, pmem_read}, 32'h1);
        check("t1_pmem_write", {31'b0, pmem_write}, 32'h0);
        check("t1_pmem_address", pmem_address, 32'h0000_0100);
        tick();
        check("t1_pmem_read_held", {31'b0, pmem_read}, 32'h1);
        tick();
        pmem_resp = 1'b1; pmem_rdata = 32'hDEAD_BEEF; #1;
        check("t1_no_resp_in_fill", {31'b0, resp_b}, 32'h0);
        tick();
        pmem_resp = 1'b0; pmem_rdata = 32'h0; #1;
        check("t1_resp_b", {31'b0, resp_b}, 32'h1);
        check("t1_rdata_b", rdata_b, 32'hDEAD_BEEF);
        check("t1_pmem_read_drop", {31'b0, pmem_read}, 32'h0);
        read_b = 1'b0;
        tick();
        check("t1_resp_single", {31'b0, resp_b}, 32'h0);

        // 2: read hit 0x100
        read_b = 1'b1; address_b = 32'h0000_0100; #1;
        check("t2_hit_resp", {31'b0, resp_b}, 32'h1);
        check("t2_hit_rdata", rdata_b, 32'hDEAD_BEEF);
        check("t2_no_pmem_read", {31'b0, pmem_read}, 32'h0);
        tick();
        read_b = 1'b0;
        tick();

        // 3: store hit 0x100, low halfword
        write = 1'b1; address_b = 32'h0000_0100; wmask = 4'b0011; wdata = 32'h0000_CAFE; #1;
        check("t3_idle_no_resp", {31'b0, resp_b}, 32'h0);
        tick();
        check("t3_pmem_write", {31'b0, pmem_write}, 32'h1);
        check("t3_pmem_read", {31'b0, pmem_read}, 32'h0);
        check("t3_pmem_address", pmem_address, 32'h0000_0100);
        check("t3_pmem_wdata", pmem_wdata, 32'h0000_CAFE);
        check("t3_pmem_wmask", {28'b0, pmem_wmask}, 32'h3);
        check("t3_wait_no_resp", {31'b0, resp_b}, 32'h0);
        tick();
        pmem_resp = 1'b1; #1;
        check("t3_resp_b", {31'b0, resp_b}, 32'h1);
        tick();
        pmem_resp = 1'b0; write = 1'b0; wmask = '0; wdata = '0; #1;
        check("t3_pmem_write_drop", {31'b0, pmem_write}, 32'h0);
        read_b = 1'b1; #1;
        check("t3_read_hit", {31'b0, resp_b}, 32'h1);
        check("t3_read_merged", rdata_b, 32'hDEAD_CAFE);
        tick();
        read_b = 1'b0;
        tick();

        // 4: store miss 0x200 (index 0, other tag) must not allocate
        write = 1'b1; address_b = 32'h0000_0200; wmask = 4'b1111; wdata = 32'h1234_5678;
        tick();
        check("t4_pmem_address", pmem_address, 32'h0000_0200);
        pmem_resp = 1'b1; #1;
        check("t4_resp_b", {31'b0, resp_b}, 32'h1);
        tick();
        pmem_resp = 1'b0; write = 1'b0; wmask = '0; wdata = '0;
        read_b = 1'b1; address_b = 32'h0000_0100; #1;
        check("t4_read_still_hit", {31'b0, resp_b}, 32'h1);
        check("t4_read_data", rdata_b, 32'hDEAD_CAFE);
        tick();
        read_b = 1'b0;
        address_b = 32'h0000_0200; #1;
        tick();
        read_b = 1'b1; #1;
        check("t4_0x200_not_alloc", {31'b0, resp_b}, 32'h0);
        read_b = 1'b0;
        tick();

        // 5: read 0x120 aliases index 0, fill replaces the line
        read_b = 1'b1; address_b = 32'h0000_0120; #1;
        check("t5_miss", {31'b0, resp_b}, 32'h0);
        tick();
        check("t5_pmem_address", pmem_address, 32'h0000_0120);
        pmem_resp = 1'b1; pmem_rdata = 32'h55AA_33CC;
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0; #1;
        check("t5_resp_b", {31'b0, resp_b}, 32'h1);
        check("t5_rdata_b", rdata_b, 32'h55AA_33CC);
        read_b = 1'b0;
        tick();
        read_b = 1'b1; address_b = 32'h0000_0100; #1;
        check("t5_0x100_misses", {31'b0, resp_b}, 32'h0);
        tick();
        check("t5_refetch_read", {31'b0, pmem_read}, 32'h1);

        // 6: reset mid-FETCH drops pmem_read at once and clears valid
        reset = 1'b0; #1;
        check("t6_pmem_read_drop", {31'b0, pmem_read}, 32'h0);
        check("t6_pmem_addr_zero", pmem_address, 32'h0);
        read_b = 1'b0;
        #2 reset = 1'b1;
        tick();
        read_b = 1'b1; address_b = 32'h0000_0120; #1;
        check("t6_0x120_misses", {31'b0, resp_b}, 32'h0);
        read_b = 1'b0;
        tick();
        read_b = 1'b1; address_b = 32'h0000_0100; #1;
        check("t6_0x100_misses", {31'b0, resp_b}, 32'h0);
        tick();
        check("t6_fetch_again", {31'b0, pmem_read}, 32'h1);
        pmem_resp = 1'b1; pmem_rdata = 32'hA5A5_0F0F;
        tick();
        pmem_resp = 1'b0; #1;
        check("t6_refill_data", rdata_b, 32'hA5A5_0F0F);
        read_b = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
